sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Two-port arbiter between the SDRAM controller and its requesters: the video line fetcher (port V, burst reads) and the CPU bus bridge (port C, reads/writes). It muxes the granted requester's rd/wr/addr/wdata/ack onto the single controller port and routes rdy back to the granted requester only. Video has priority, with a starvation bound so CPU traffic always progresses. It sits between the video controller / CPU bridge and the SDRAM controller.

## Interface
- STARVE_LIMIT, 2: consecutive V grants allowed while C is pending before C is forced next.
- ADDR_W, 24: word-address width (16-bit words, 32 MB).
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous, active-low reset.
- v_rd_i  in  1  video read request; held until v_ack_i.
- v_addr_i  in  ADDR_W  video burst start address.
- v_ack_i  in  1  one-cycle strobe from video: transaction finished.
- v_rdy_o  out  1  controller rdy, gated to V.
- c_rd_i, c_wr_i  in  1 each  CPU request; mutually exclusive, held until c_ack_i.
- c_addr_i  in  ADDR_W  CPU word address.
- c_wdata_i  in  16  CPU write data.
- c_ack_i  in  1  one-cycle strobe from CPU bridge: transaction finished.
- c_rdy_o  out  1  controller rdy, gated to C.
- mem_rd_o, mem_wr_o  out  1 each  to controller.
- mem_addr_o  out  ADDR_W  to controller.
- mem_wdata_o  out  16  to controller.
- mem_ack_o  out  1  granted requester's ack, forwarded.
- mem_rdy_i  in  1  controller data-ready/word-accepted.
- grant_o  out  2  current state encoding, debug.

## Operation
- States: IDLE, GNT_V, GNT_C, RELEASE. grant_o = 0/1/2/3 respectively.
- IDLE: if v_rd_i and (not C pending or starve_cnt < STARVE_LIMIT) -> GNT_V; else if C pending (c_rd_i|c_wr_i) -> GNT_C; else stay.
- GNT_V: mem_* driven from V (mem_wr_o=0, mem_wdata_o=0); v_rdy_o = mem_rdy_i; c_rdy_o = 0. On v_ack_i -> RELEASE.
- GNT_C: mem_* driven from C; c_rdy_o = mem_rdy_i; v_rdy_o = 0. On c_ack_i -> RELEASE.
- RELEASE: exactly one cycle, mem_rd_o=mem_wr_o=0, both rdy 0; -> IDLE. Guarantees the controller sees request low between owners.
- starve_cnt (width clog2(STARVE_LIMIT+1)): on entry to GNT_V with C pending, increment (saturating); on entry to GNT_C, clear; on entry to GNT_V with C idle, clear.
- Ack from the non-granted port is ignored. Request drop without ack is a protocol violation; arbiter keeps grant (no timeout).
- mem_ack_o = v_ack_i in GNT_V, c_ack_i in GNT_C, else 0.

## Timing
- State register only sequential element besides starve_cnt; all mem_* and rdy outputs are combinational from state and inputs.
- Request-to-grant latency: request seen in IDLE at edge N -> mem_rd_o/mem_wr_o high during cycle N+1.
- Back-to-back: ack at edge N -> RELEASE cycle N+1 -> IDLE N+2 -> next grant visible N+3. Minimum gap between owners 2 idle cycles on mem_*.
- Simultaneous V and C in IDLE with starve_cnt < STARVE_LIMIT: V wins; with starve_cnt == STARVE_LIMIT: C wins.
- Ack in same cycle rdy asserted: rdy still forwarded that cycle; state leaves next edge.
- Reset (async assert): state=IDLE, starve_cnt=0; all outputs 0 (mem_rd_o, mem_wr_o, mem_addr_o, mem_wdata_o, mem_ack_o, v_rdy_o, c_rdy_o, grant_o) immediately, independent of clk_i. Mid-transaction reset abandons the burst; deassertion is synchronised externally.

## Structure
- Shared package poly94_mem_pkg: typedef arb_state_e (IDLE, GNT_V, GNT_C, RELEASE), typedef mem_req_t struct {rd, wr, addr[ADDR_W-1:0], wdata[15:0]}, constant SDRAM_ADDR_W = 24.
- No sub-module: FSM plus saturating counter plus output mux fit in one module.

## Test plan
- V only: v_rd_i=1, addr 0x080000, mem_rdy_i pulsed 64 times, v_ack_i on 64th -> mem_addr_o=0x080000 from cycle 1, v_rdy_o mirrors all 64 pulses, mem_rd_o low 1 cycle after ack, grant_o 1->3->0.
- C write: c_wr_i=1, addr 0x000010, wdata 0xBEEF -> mem_wr_o=1, mem_wdata_o=0xBEEF, v_rdy_o stays 0 while mem_rdy_i pulses.
- Simultaneous V and C from reset -> V granted first; after V ack, C granted (V deasserted) with 2 idle cycles on mem_rd_o/mem_wr_o between.
- Starvation, STARVE_LIMIT=2: V requests continuously, C pending -> grant sequence V, V, C, V; starve_cnt resets after C.
- Stray ack: c_ack_i pulsed during GNT_V -> no state change, mem_ack_o=0.
- Async reset asserted mid-burst (no clock edge) -> all outputs 0 within same cycle; after release, pending V request granted 1 cycle after first edge.

Source files
------------

// File: rtl/poly94_mem_pkg.sv
// Shared memory-subsystem types: arbiter state encoding and the request
// bundle that is muxed onto the SDRAM controller port.
package poly94_mem_pkg;

   localparam int SDRAM_ADDR_W = 24;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_V   = 2'd1,
      GNT_C   = 2'd2,
      RELEASE = 2'd3
   } arb_state_e;

   typedef struct packed {
      logic                    rd;
      logic                    wr;
      logic [SDRAM_ADDR_W-1:0] addr;
      logic [15:0]             wdata;
   } mem_req_t;

   function automatic mem_req_t mem_req_idle();
      mem_req_t r;
      r = '0;
      return r;
   endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bundle of the video, CPU and controller-side signals around the arbiter.
// Directions are named from the arbiter's point of view (slave modport).
interface sdram_arbiter_if
   import poly94_mem_pkg::*;
#(
   parameter int ADDR_W = SDRAM_ADDR_W
);
   logic              v_rd_i;
   logic [ADDR_W-1:0] v_addr_i;
   logic              v_ack_i;
   logic              v_rdy_o;

   logic              c_rd_i;
   logic              c_wr_i;
   logic [ADDR_W-1:0] c_addr_i;
   logic [15:0]       c_wdata_i;
   logic              c_ack_i;
   logic              c_rdy_o;

   logic              mem_rd_o;
   logic              mem_wr_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [15:0]       mem_wdata_o;
   logic              mem_ack_o;
   logic              mem_rdy_i;

   logic [1:0]        grant_o;

   modport slave (
      input  v_rd_i, v_addr_i, v_ack_i,
      input  c_rd_i, c_wr_i, c_addr_i, c_wdata_i, c_ack_i,
      input  mem_rdy_i,
      output v_rdy_o, c_rdy_o,
      output mem_rd_o, mem_wr_o, mem_addr_o, mem_wdata_o, mem_ack_o,
      output grant_o
   );

   modport master (
      output v_rd_i, v_addr_i, v_ack_i,
      output c_rd_i, c_wr_i, c_addr_i, c_wdata_i, c_ack_i,
      output mem_rdy_i,
      input  v_rdy_o, c_rdy_o,
      input  mem_rd_o, mem_wr_o, mem_addr_o, mem_wdata_o, mem_ack_o,
      input  grant_o
   );

endinterface

// File: rtl/sdram_arbiter.sv
// Two-port SDRAM arbiter: video (burst reads) has priority over the CPU
// bridge, with a starvation bound so CPU traffic always gets through.
//
//   state   | meaning
//   IDLE    | no owner, mem_* quiet, pick next owner
//   GNT_V   | video owns the controller port until v_ack_i
//   GNT_C   | CPU owns the controller port until c_ack_i
//   RELEASE | one quiet cycle so the controller sees request low between owners
module sdram_arbiter
   import poly94_mem_pkg::*;
#(
   parameter int STARVE_LIMIT = 2,
   parameter int ADDR_W       = SDRAM_ADDR_W
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   sdram_arbiter_if.slave  bus
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] starve_q, starve_d;
   logic             c_pend;
   logic             v_wins;
   mem_req_t         req;
   logic             v_rdy, c_rdy, ack;

   assign c_pend = bus.c_rd_i | bus.c_wr_i;
   assign v_wins = bus.v_rd_i & (~c_pend | (starve_q < CNT_MAX));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   // The counter only moves when a grant is taken, so it measures consecutive
   // video wins while the CPU is waiting.
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      unique case (state_q)
         IDLE: begin
            if (v_wins) begin
               state_d = GNT_V;
               if (!c_pend)
                  starve_d = '0;
               else if (starve_q != CNT_MAX)
                  starve_d = starve_q + 1'b1;
            end else if (c_pend) begin
               state_d  = GNT_C;
               starve_d = '0;
            end
         end
         GNT_V:   if (bus.v_ack_i) state_d = RELEASE;
         GNT_C:   if (bus.c_ack_i) state_d = RELEASE;
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req   = mem_req_idle();
      v_rdy = 1'b0;
      c_rdy = 1'b0;
      ack   = 1'b0;
      unique case (state_q)
         GNT_V: begin
            req.rd   = bus.v_rd_i;
            req.addr = SDRAM_ADDR_W'(bus.v_addr_i);
            v_rdy    = bus.mem_rdy_i;
            ack      = bus.v_ack_i;
         end
         GNT_C: begin
            req.rd    = bus.c_rd_i;
            req.wr    = bus.c_wr_i;
            req.addr  = SDRAM_ADDR_W'(bus.c_addr_i);
            req.wdata = bus.c_wdata_i;
            c_rdy     = bus.mem_rdy_i;
            ack       = bus.c_ack_i;
         end
         default: ;
      endcase
   end

   assign bus.mem_rd_o    = req.rd;
   assign bus.mem_wr_o    = req.wr;
   assign bus.mem_addr_o  = req.addr[ADDR_W-1:0];
   assign bus.mem_wdata_o = req.wdata;
   assign bus.mem_ack_o   = ack;
   assign bus.v_rdy_o     = v_rdy;
   assign bus.c_rdy_o     = c_rdy;
   assign bus.grant_o     = state_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: grants are checked against a queue of
// expected owners filled as requests are raised.
module tb_sdram_arbiter;
   import poly94_mem_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sdram_arbiter_if #(.ADDR_W(24)) bus ();

   sdram_arbiter #(.STARVE_LIMIT(2), .ADDR_W(24)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      logic [1:0]  g;
      logic        rd;
      logic        wr;
      logic [23:0] addr;
      logic [15:0] wdata;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] g, input logic rd, input logic wr,
                       input logic [23:0] addr, input logic [15:0] wdata);
      exp_t e;
      e.g = g; e.rd = rd; e.wr = wr; e.addr = addr; e.wdata = wdata;
      exp_q.push_back(e);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_mem_rd"},    32'(bus.mem_rd_o),    32'd0);
      chk({tag, "_mem_wr"},    32'(bus.mem_wr_o),    32'd0);
      chk({tag, "_mem_addr"},  32'(bus.mem_addr_o),  32'd0);
      chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata_o), 32'd0);
      chk({tag, "_mem_ack"},   32'(bus.mem_ack_o),   32'd0);
      chk({tag, "_v_rdy"},     32'(bus.v_rdy_o),     32'd0);
      chk({tag, "_c_rdy"},     32'(bus.c_rdy_o),     32'd0);
      chk({tag, "_grant"},     32'(bus.grant_o),     32'd0);
   endtask

   // Waits (bounded) for a V or C grant, then pops the scoreboard and checks
   // the owner and the request muxed onto mem_*.
   task automatic wait_grant(input string tag, output int waited, output int idle);
      exp_t e;
      int   n;
      n    = 0;
      idle = 0;
      while (!(bus.grant_o == 2'd1 || bus.grant_o == 2'd2) && n < 20) begin
         if (!bus.mem_rd_o && !bus.mem_wr_o) idle++;
         step();
         n++;
      end
      waited = n;
      chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, "_grant"}, 32'(bus.grant_o),     32'(e.g));
         chk({tag, "_rd"},    32'(bus.mem_rd_o),    32'(e.rd));
         chk({tag, "_wr"},    32'(bus.mem_wr_o),    32'(e.wr));
         chk({tag, "_addr"},  32'(bus.mem_addr_o),  32'(e.addr));
         chk({tag, "_wdata"}, 32'(bus.mem_wdata_o), 32'(e.wdata));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited, idle, rdy_seen;

      bus.v_rd_i = 0; bus.v_addr_i = '0; bus.v_ack_i = 0;
      bus.c_rd_i = 0; bus.c_wr_i = 0; bus.c_addr_i = '0; bus.c_wdata_i = '0; bus.c_ack_i = 0;
      bus.mem_rdy_i = 0;

      #12;
      chk_zero("reset");
      rst_n = 1'b1;

      // Video-only 64-word burst
      step();
      bus.v_rd_i = 1; bus.v_addr_i = 24'h080000;
      push(2'd1, 1'b1, 1'b0, 24'h080000, 16'h0);
      wait_grant("v_only", waited, idle);
      chk("v_only_latency", 32'(waited), 32'd1);
      rdy_seen = 0;
      for (int i = 0; i < 64; i++) begin
         bus.mem_rdy_i = 1;
         bus.v_ack_i   = (i == 63);
         #1;
         if (bus.v_rdy_o === 1'b1) rdy_seen++;
         chk("v_only_c_rdy", 32'(bus.c_rdy_o), 32'd0);
         chk("v_only_addr", 32'(bus.mem_addr_o), 32'h080000);
         chk("v_only_mem_ack", 32'(bus.mem_ack_o), 32'(i == 63));
         step();
         bus.mem_rdy_i = 0;
         bus.v_ack_i   = 0;
         #1;
         chk("v_only_rdy_low", 32'(bus.v_rdy_o), 32'd0);
         chk("v_only_grant", 32'(bus.grant_o), (i == 63) ? 32'd3 : 32'd1);
      end
      chk("v_only_rdy_pulses", 32'(rdy_seen), 32'd64);
      chk("v_only_release_rd", 32'(bus.mem_rd_o), 32'd0);
      bus.v_rd_i = 0;
      step();
      chk("v_only_idle_grant", 32'(bus.grant_o), 32'd0);
      chk("v_only_idle_rd", 32'(bus.mem_rd_o), 32'd0);

      // CPU write
      bus.c_wr_i = 1; bus.c_addr_i = 24'h000010; bus.c_wdata_i = 16'hBEEF;
      push(2'd2, 1'b0, 1'b1, 24'h000010, 16'hBEEF);
      wait_grant("c_wr", waited, idle);
      chk("c_wr_latency", 32'(waited), 32'd1);
      for (int i = 0; i < 3; i++) begin
         bus.mem_rdy_i = 1;
         #1;
         chk("c_wr_v_rdy", 32'(bus.v_rdy_o), 32'd0);
         chk("c_wr_c_rdy", 32'(bus.c_rdy_o), 32'd1);
         step();
         bus.mem_rdy_i = 0;
         #1;
         chk("c_wr_c_rdy_low", 32'(bus.c_rdy_o), 32'd0);
      end
      bus.c_ack_i = 1;
      #1;
      chk("c_wr_mem_ack", 32'(bus.mem_ack_o), 32'd1);
      step();
      bus.c_ack_i = 0; bus.c_wr_i = 0;
      #1;
      chk("c_wr_release", 32'(bus.grant_o), 32'd3);
      chk("c_wr_release_wr", 32'(bus.mem_wr_o), 32'd0);
      step();
      chk("c_wr_idle", 32'(bus.grant_o), 32'd0);

      // Simultaneous V and C straight out of reset
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      bus.v_rd_i = 1; bus.v_addr_i = 24'h0A0000;
      bus.c_rd_i = 1; bus.c_addr_i = 24'h001234; bus.c_wdata_i = 16'h0;
      push(2'd1, 1'b1, 1'b0, 24'h0A0000, 16'h0);
      push(2'd2, 1'b1, 1'b0, 24'h001234, 16'h0);
      wait_grant("sim_v", waited, idle);
      bus.mem_rdy_i = 1;
      bus.v_ack_i   = 1;
      #1;
      chk("sim_v_rdy_with_ack", 32'(bus.v_rdy_o), 32'd1);
      chk("sim_c_rdy_gated", 32'(bus.c_rdy_o), 32'd0);
      chk("sim_v_mem_ack", 32'(bus.mem_ack_o), 32'd1);
      step();
      bus.v_ack_i = 0; bus.mem_rdy_i = 0; bus.v_rd_i = 0;
      #1;
      wait_grant("sim_c", waited, idle);
      chk("sim_gap_idle", 32'(idle), 32'd2);
      bus.c_ack_i = 1;
      step();
      bus.c_ack_i = 0; bus.c_rd_i = 0;
      step();
      chk("sim_idle", 32'(bus.grant_o), 32'd0);

      // Starvation bound with both requesters held, plus a stray CPU ack
      bus.v_rd_i = 1; bus.v_addr_i = 24'h0C0000;
      bus.c_rd_i = 1; bus.c_addr_i = 24'h002000;
      push(2'd1, 1'b1, 1'b0, 24'h0C0000, 16'h0);
      push(2'd1, 1'b1, 1'b0, 24'h0C0000, 16'h0);
      push(2'd2, 1'b1, 1'b0, 24'h002000, 16'h0);
      push(2'd1, 1'b1, 1'b0, 24'h0C0000, 16'h0);
      for (int k = 0; k < 4; k++) begin
         wait_grant($sformatf("starve%0d", k), waited, idle);
         if (k == 0) begin
            bus.c_ack_i = 1;
            #1;
            chk("stray_mem_ack", 32'(bus.mem_ack_o), 32'd0);
            step();
            bus.c_ack_i = 0;
            #1;
            chk("stray_grant", 32'(bus.grant_o), 32'd1);
         end
         if (k == 2) bus.c_ack_i = 1;
         else        bus.v_ack_i = 1;
         step();
         bus.c_ack_i = 0; bus.v_ack_i = 0;
      end
      bus.v_rd_i = 0; bus.c_rd_i = 0;
      step();
      step();
      chk("starve_idle", 32'(bus.grant_o), 32'd0);

      // Asynchronous reset in the middle of a burst
      bus.v_rd_i = 1; bus.v_addr_i = 24'h0E0000;
      push(2'd1, 1'b1, 1'b0, 24'h0E0000, 16'h0);
      wait_grant("pre_rst", waited, idle);
      bus.mem_rdy_i = 1;
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      #2;
      rst_n = 1'b1;
      bus.mem_rdy_i = 0;
      push(2'd1, 1'b1, 1'b0, 24'h0E0000, 16'h0);
      wait_grant("post_rst", waited, idle);
      chk("post_rst_latency", 32'(waited), 32'd1);
      bus.v_ack_i = 1;
      step();
      bus.v_ack_i = 0; bus.v_rd_i = 0;
      step();
      chk("final_idle", 32'(bus.grant_o), 32'd0);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
